// File: rtl/router_pkg.sv
// router_pkg
// Shared definitions for the 1x3 router: packet byte width, per-port FIFO
// depth and pointer width, header field positions and the width of the
// per-packet byte counter. The synchronizer, register stage and output
// FIFOs all import this package so they agree on packet framing.
//
// Contents:
//   DATA_W      packet byte width
//   FIFO_DEPTH  entries per output FIFO (power of two)
//   PTR_W       FIFO pointer width, including the wrap bit
//   ADDR_*      header destination-address field [1:0]
//   LEN_*       header payload-length field [7:2]
//   CNT_W       width of the read-side packet byte counter
//   next_count  counter value loaded when a header byte is read

package router_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int PTR_W      = $clog2(FIFO_DEPTH) + 1;

    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 1;
    localparam int LEN_LSB  = 2;
    localparam int LEN_MSB  = 7;
    localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

    localparam int CNT_W = 6;

    // Remaining bytes after a header: payload length plus one parity byte.
    // The sum is formed one bit wider than the counter so a maximum-length
    // header saturates instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] next_count(input logic [LEN_W-1:0] len);
        logic [CNT_W:0] sum;
        sum = (CNT_W+1)'(len) + (CNT_W+1)'(1);
        if (sum[CNT_W]) begin
            next_count = '1;
        end else begin
            next_count = sum[CNT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/router_fifo_ram.sv
// router_fifo_ram
// Storage array for one router output FIFO: simple dual-port, synchronous
// write, asynchronous read. Contents are never cleared; the FIFO pointers
// alone decide which entries are meaningful.
//
// Ports:
//   clk    write clock (rising edge)
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  combinational read data at raddr

module router_fifo_ram #(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: one entry per enabled clock edge, no reset on the array.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: combinational, so the FIFO can register data_out directly.
    assign rdata = mem[raddr];

endmodule

// File: rtl/router_fifo.sv
// router_fifo
// Per-destination output FIFO of the 1x3 router. Each entry holds one packet
// byte plus a header flag. The read side uses the flag to load a byte
// counter from the header length field, and blanks data_out to zero once a
// packet has been fully delivered and no further read is taking place.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   soft_rst   synchronous clear (read timeout from the synchronizer)
//   write_en   write request
//   lfd_state  byte being written is a packet header
//   data_in    byte to write
//   read_en    read request from the destination
//   data_out   registered read data
//   full       no free entry
//   empty      no stored entry

module router_fifo #(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int DEPTH  = router_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_rst,
    input  logic              write_en,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_en,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty
);

    import router_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  byte_cnt;
    logic [DATA_W:0]   rd_entry;
    logic              wr_ok;
    logic              rd_ok;
    logic              ram_we;

    // Flags come straight from the current pointers; the MSB is the wrap bit
    // that distinguishes a full FIFO from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

    assign wr_ok  = write_en && !full;
    assign rd_ok  = read_en && !empty;

    // A soft reset discards any write presented in the same cycle.
    assign ram_we = wr_ok && !soft_rst;

    router_fifo_ram #(
        .WIDTH  (DATA_W + 1),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({lfd_state, data_in}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_entry)
    );

    // Pointers, packet counter and output register. Hard reset beats soft
    // reset, which beats any read or write. A read loads the counter from
    // a header's length field or counts a payload/parity byte down; with no
    // read and nothing left of the current packet, data_out is blanked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            byte_cnt <= '0;
            data_out <= '0;
        end else if (soft_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            byte_cnt <= '0;
            data_out <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + PW'(1);
                data_out <= rd_entry[DATA_W-1:0];
                if (rd_entry[DATA_W]) begin
                    byte_cnt <= next_count(rd_entry[LEN_MSB:LEN_LSB]);
                end else if (byte_cnt != '0) begin
                    byte_cnt <= byte_cnt - CNT_W'(1);
                end
            end else if (byte_cnt == '0) begin
                data_out <= '0;
            end
        end
    end

endmodule

// File: doc/router_fifo.md
# router_fifo

Per-port output FIFO of the 1x3 router, directly downstream of the synchronizer. Three instances exist, one per destination port. Each instance takes its `write_en[i]` and `soft_rst_i` from the synchronizer, and returns `full_i` and `empty_i` to it. Each entry stores one packet byte plus a header flag, so that the read side can track packet boundaries and blank `data_out` between packets.

## Interface
- `DATA_W`, default 8: packet byte width.
- `DEPTH`, default 16: entries; must be a power of two.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `soft_rst` input 1: synchronous clear from the synchronizer's read timeout.
- `write_en` input 1: write request; one of the synchronizer's `write_en[2:0]` bits.
- `lfd_state` input 1: the byte being written is a packet header.
- `data_in` input `DATA_W`: byte to write.
- `read_en` input 1: read request from the destination.
- `data_out` output `DATA_W`: registered read data.
- `full` output 1: no free entry.
- `empty` output 1: no stored entry.

## Operation
- Storage is `DEPTH` x (`DATA_W`+1). Bit `DATA_W` holds the header flag, taken from `lfd_state`.
- `wr_ptr` and `rd_ptr` are each log2(`DEPTH`)+1 bits wide. The extra MSB is the wrap bit.
- `empty` = (`wr_ptr` == `rd_ptr`).
- `full` = MSBs differ and the low bits are equal.
- Both flags are combinational from the pointers.
- Write: when `write_en` && !`full`:
  - store {`lfd_state`, `data_in`} at `wr_ptr`;
  - increment `wr_ptr`, modulo 2*`DEPTH`.
  - A write while full is dropped. No pointer or memory change.
- Read: when `read_en` && !`empty`:
  - `data_out` <= stored byte;
  - increment `rd_ptr`.
  - A read while empty is ignored.
- Packet counter `byte_cnt` is 6 bits.
  - On a valid read of an entry with the header flag set: `byte_cnt` <= header[7:2] + 1. This counts payload plus parity and is computed 7 bits wide, then saturates at 63.
  - On a valid read of a non-header entry with `byte_cnt` != 0: decrement `byte_cnt`.
- Blanking: on a cycle with no valid read and `byte_cnt` == 0, `data_out` <= 0. Otherwise `data_out` holds.
- Simultaneous read and write:
  - Both proceed when neither `full` nor `empty`.
  - When full, only the read proceeds. When empty, only the write proceeds.
  - Flags are evaluated on current pointers, not bypassed.
- Priority order: `rst` > `soft_rst` > read/write.

## Timing
- Reset values under `rst` (async) or `soft_rst` (next edge):
  - `wr_ptr` = `rd_ptr` = 0;
  - `byte_cnt` = 0;
  - `data_out` = 0;
  - hence `empty` = 1 and `full` = 0.
- Memory contents are not cleared by either reset.
- `soft_rst` discards any write or read presented in the same cycle.
- Write-to-`empty` deassert: 1 cycle. `empty` falls after the edge that writes.
- Read latency: 1 cycle. `data_out` is valid after the edge that samples `read_en`.
- `full` asserts after the edge of the `DEPTH`-th unread write. It falls after the first subsequent read edge.
- Reset asserted mid-packet: all state is cleared immediately. The next edge after `rst` falls behaves as a fresh FIFO.

## Structure
- Shared `router_pkg` holds:
  - `DATA_W`, `FIFO_DEPTH`, `PTR_W`;
  - the header field positions: addr [1:0], length [7:2];
  - the `byte_cnt` width.
  The synchronizer and register stage use the same package.
- One natural sub-module, `router_fifo_ram`. It is a simple dual-port, synchronous-write, async-read array. Pointers, flags, counter and the `data_out` register stay in `router_fifo`.

## Test plan
- Reset check:
  - Assert `rst` mid-cycle -> immediately `empty`=1, `full`=0, `data_out`=0.
  - Release, read with `read_en`=1 -> `data_out` stays 0.
- Packet flow:
  - Write header 0x0C with `lfd_state`=1 (length 3, addr 0), payload 0xA1, 0xA2, 0xA3, parity 0x5E.
  - Read 5 times -> `data_out` = 0x0C, A1, A2, A3, 5E on consecutive cycles.
  - `byte_cnt` 4 -> 0.
  - `data_out` = 0 on the next idle cycle; `empty`=1.
- Fill and overflow:
  - 16 writes -> `full`=1 after the 16th.
  - 17th write of 0xFF is dropped.
  - Reading 16 entries returns the original 16 bytes in order; `empty`=1 afterwards.
- Wrap-around:
  - Write 10, read 10, then write 16 -> `full`=1 with `wr_ptr` MSB toggled.
  - Data reads back correctly across the index-15 -> 0 boundary.
- Simultaneous read/write:
  - At 8 entries: both for 20 cycles -> occupancy stays 8, in-order data.
  - At full: read+write -> only the read occurs, `full` falls.
  - At empty: read+write -> only the write occurs, `data_out` unchanged.
- Soft reset:
  - With 5 entries stored, pulse `soft_rst` concurrently with `write_en` and `read_en`.
  - Next cycle: `empty`=1, `data_out`=0, no write landed.
  - A new header/packet then flows normally.
